// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// Optional misaligned-redirect trap tagging is built when IF_MISALIGN_TRAP_EN is defined.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_stall,
   input  logic        i_flush,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic [31:0] o_pc,
   input  logic [31:0] i_instr,
   output logic [31:0] o_if_id_pc,
   output logic [31:0] o_if_id_pc4,
   output logic [31:0] o_if_id_instr,
   output logic        o_if_id_valid,
   output logic        o_if_id_misalign
);

   logic [31:0] pc_r;
   logic [31:0] pc_next_s;
   logic [31:0] pc_plus4_s;
   logic [31:0] redirect_tgt_s;

   logic [31:0] if_id_pc_r;
   logic [31:0] if_id_pc4_r;
   logic [31:0] if_id_instr_r;
   logic        if_id_valid_r;
   logic        if_id_misalign_r;

   logic [31:0] if_id_pc_next_s;
   logic [31:0] if_id_pc4_next_s;
   logic [31:0] if_id_instr_next_s;
   logic        if_id_valid_next_s;
   logic        if_id_misalign_next_s;

   // Fetched word and trap tag written on a normal IF/ID load
   logic [31:0] load_instr_s;
   logic        load_misalign_s;

   assign pc_plus4_s     = pc_r + 32'd4;
   assign redirect_tgt_s = {i_redirect_pc[31:2], 2'b00};

`ifdef IF_MISALIGN_TRAP_EN
   logic pending_r;
   logic pending_next_s;

   // A pending misaligned target replaces the fetched word with a tagged bubble
   assign load_instr_s    = pending_r ? NOP_INSTR : i_instr;
   assign load_misalign_s = pending_r;

   // Pending-trap flag: set by a misaligned redirect, consumed by the next load
   always_comb begin
      pending_next_s = pending_r;
      if (i_redirect) begin
         pending_next_s = (i_redirect_pc[1:0] != 2'b00);
      end else if (i_flush) begin
         pending_next_s = 1'b0;
      end else if (i_stall) begin
         pending_next_s = pending_r;
      end else begin
         pending_next_s = 1'b0;
      end
   end

   // Pending-trap flag register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         pending_r <= 1'b0;
      end else begin
         pending_r <= pending_next_s;
      end
   end
`else
   logic tgt_lsb_unused_s;

   // Low target bits are dropped; no trap tagging in this build
   assign tgt_lsb_unused_s = |i_redirect_pc[1:0];
   assign load_instr_s     = i_instr;
   assign load_misalign_s  = 1'b0;
`endif

   // Next-PC select: redirect beats stall, otherwise advance one word
   always_comb begin
      pc_next_s = pc_r;
      if (i_redirect) begin
         pc_next_s = redirect_tgt_s;
      end else if (i_stall) begin
         pc_next_s = pc_r;
      end else begin
         pc_next_s = pc_plus4_s;
      end
   end

   // IF/ID next-state: a redirect squashes the wrong-path fetch even while stalled
   always_comb begin
      if_id_pc_next_s       = if_id_pc_r;
      if_id_pc4_next_s      = if_id_pc4_r;
      if_id_instr_next_s    = if_id_instr_r;
      if_id_valid_next_s    = if_id_valid_r;
      if_id_misalign_next_s = if_id_misalign_r;
      if (i_flush || i_redirect) begin
         if_id_pc_next_s       = 32'h0000_0000;
         if_id_pc4_next_s      = 32'h0000_0000;
         if_id_instr_next_s    = NOP_INSTR;
         if_id_valid_next_s    = 1'b0;
         if_id_misalign_next_s = 1'b0;
      end else if (i_stall) begin
         if_id_pc_next_s       = if_id_pc_r;
         if_id_pc4_next_s      = if_id_pc4_r;
         if_id_instr_next_s    = if_id_instr_r;
         if_id_valid_next_s    = if_id_valid_r;
         if_id_misalign_next_s = if_id_misalign_r;
      end else begin
         if_id_pc_next_s       = pc_r;
         if_id_pc4_next_s      = pc_plus4_s;
         if_id_instr_next_s    = load_instr_s;
         if_id_valid_next_s    = 1'b1;
         if_id_misalign_next_s = load_misalign_s;
      end
   end

   // PC and IF/ID registers; reset overrides every other control
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         pc_r             <= RESET_PC;
         if_id_pc_r       <= 32'h0000_0000;
         if_id_pc4_r      <= 32'h0000_0000;
         if_id_instr_r    <= NOP_INSTR;
         if_id_valid_r    <= 1'b0;
         if_id_misalign_r <= 1'b0;
      end else begin
         pc_r             <= pc_next_s;
         if_id_pc_r       <= if_id_pc_next_s;
         if_id_pc4_r      <= if_id_pc4_next_s;
         if_id_instr_r    <= if_id_instr_next_s;
         if_id_valid_r    <= if_id_valid_next_s;
         if_id_misalign_r <= if_id_misalign_next_s;
      end
   end

   assign o_pc             = pc_r;
   assign o_if_id_pc       = if_id_pc_r;
   assign o_if_id_pc4      = if_id_pc4_r;
   assign o_if_id_instr    = if_id_instr_r;
   assign o_if_id_valid    = if_id_valid_r;
   assign o_if_id_misalign = if_id_misalign_r;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: reference model feeds a scoreboard queue,
// plus directed spot checks of the documented fetch scenarios.
module tb_if_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ipc;
      logic [31:0] ipc4;
      logic [31:0] instr;
      logic        valid;
      logic        mis;
   } exp_t;

   logic        clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_stall = 1'b0;
   logic        i_flush = 1'b0;
   logic        i_redirect = 1'b0;
   logic [31:0] i_redirect_pc = 32'h0000_0000;
   logic [31:0] o_pc;
   logic [31:0] i_instr;
   logic [31:0] o_if_id_pc;
   logic [31:0] o_if_id_pc4;
   logic [31:0] o_if_id_instr;
   logic        o_if_id_valid;
   logic        o_if_id_misalign;

   logic [31:0] mem [0:63];
   exp_t        sb [$];

   int vectors = 0;
   int miscompares = 0;

   // bench-side reference state
   logic [31:0] m_pc = RESET_PC;
   logic [31:0] m_ipc = 32'h0;
   logic [31:0] m_ipc4 = 32'h0;
   logic [31:0] m_instr = NOP;
   logic        m_valid = 1'b0;
   logic        m_mis = 1'b0;
   logic        m_pend = 1'b0;

   always #5 clk = ~clk;

   // imem model: combinational read, aliases above 64 words
   assign i_instr = mem[o_pc[7:2]];

   if_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
      .i_clk(clk),
      .i_reset(i_reset),
      .i_stall(i_stall),
      .i_flush(i_flush),
      .i_redirect(i_redirect),
      .i_redirect_pc(i_redirect_pc),
      .o_pc(o_pc),
      .i_instr(i_instr),
      .o_if_id_pc(o_if_id_pc),
      .o_if_id_pc4(o_if_id_pc4),
      .o_if_id_instr(o_if_id_instr),
      .o_if_id_valid(o_if_id_valid),
      .o_if_id_misalign(o_if_id_misalign)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic model(input logic rst, input logic st, input logic fl, input logic rd,
                        input logic [31:0] rpc);
      logic [31:0] npc;
      logic        np;
      if (rst) begin
         m_pc = RESET_PC; m_ipc = 32'h0; m_ipc4 = 32'h0;
         m_instr = NOP; m_valid = 1'b0; m_mis = 1'b0; m_pend = 1'b0;
      end else begin
         npc = rd ? {rpc[31:2], 2'b00} : (st ? m_pc : m_pc + 32'd4);
         np  = m_pend;
`ifdef IF_MISALIGN_TRAP_EN
         if (rd) np = (rpc[1:0] != 2'b00);
         else if (fl) np = 1'b0;
         else if (!st) np = 1'b0;
`endif
         if (fl || rd) begin
            m_ipc = 32'h0; m_ipc4 = 32'h0; m_instr = NOP; m_valid = 1'b0; m_mis = 1'b0;
         end else if (!st) begin
            m_ipc   = m_pc;
            m_ipc4  = m_pc + 32'd4;
            m_valid = 1'b1;
            m_instr = m_pend ? NOP : mem[m_pc[7:2]];
            m_mis   = m_pend;
         end
         m_pc   = npc;
         m_pend = np;
      end
   endtask

   // drive one cycle, push the model's prediction, compare after the edge
   task automatic step(input logic rst, input logic st, input logic fl, input logic rd,
                       input logic [31:0] rpc, input string tag);
      exp_t e;
      i_reset = rst; i_stall = st; i_flush = fl; i_redirect = rd; i_redirect_pc = rpc;
      model(rst, st, fl, rd, rpc);
      e.pc = m_pc; e.ipc = m_ipc; e.ipc4 = m_ipc4;
      e.instr = m_instr; e.valid = m_valid; e.mis = m_mis;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({tag, ".pc"},    o_pc,                     e.pc);
      chk({tag, ".ipc"},   o_if_id_pc,               e.ipc);
      chk({tag, ".ipc4"},  o_if_id_pc4,              e.ipc4);
      chk({tag, ".instr"}, o_if_id_instr,            e.instr);
      chk({tag, ".valid"}, {31'd0, o_if_id_valid},   {31'd0, e.valid});
      chk({tag, ".mis"},   {31'd0, o_if_id_misalign}, {31'd0, e.mis});
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         mem[i] = 32'hC0DE_0000 | (i * 32'h0000_0101);
      end

      // 1: reset and sequential fetch
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, "rst0");
      step(1'b1, 1'b1, 1'b0, 1'b1, 32'h80, "rst1");
      chk("rst.pc", o_pc, RESET_PC);
      chk("rst.valid", {31'd0, o_if_id_valid}, 32'd0);
      chk("rst.instr", o_if_id_instr, NOP);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "seq0");
      chk("t1.pc4", o_pc, 32'h4);
      chk("t1.first_instr", o_if_id_instr, mem[0]);
      chk("t1.first_valid", {31'd0, o_if_id_valid}, 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "seq1");
      chk("t1.pc8", o_pc, 32'h8);

      // 2: stall three cycles at pc 8
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, "stall0");
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, "stall1");
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, "stall2");
      chk("t2.pc_hold", o_pc, 32'h8);
      chk("t2.ifid_hold", o_if_id_instr, mem[1]);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "resume");
      chk("t2.resume_pc", o_if_id_pc, 32'h8);
      chk("t2.resume_instr", o_if_id_instr, mem[2]);

      // 3: redirect at pc C
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h40, "redir40");
      chk("t3.pc", o_pc, 32'h40);
      chk("t3.bubble_instr", o_if_id_instr, 32'h0000_0013);
      chk("t3.bubble_valid", {31'd0, o_if_id_valid}, 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "after40");
      chk("t3.ifid_pc", o_if_id_pc, 32'h40);

      // 4: redirect with stall, then flush with stall
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h80, "redir_stall");
      chk("t4.pc", o_pc, 32'h80);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "after80");
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, "flush_stall");
      chk("t4.flush_pc_hold", o_pc, 32'h84);
      chk("t4.flush_valid", {31'd0, o_if_id_valid}, 32'd0);

      // 5: wrap-around, then reset mid-run with competing controls
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, "redir_top");
      chk("t5.pc_top", o_pc, 32'hFFFF_FFFC);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "wrap");
      chk("t5.pc_wrap", o_pc, 32'h0);
      chk("t5.pc4_wrap", o_if_id_pc4, 32'h0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "run");
      step(1'b1, 1'b1, 1'b0, 1'b1, 32'h40, "midrst");
      chk("t5.rst_pc", o_pc, RESET_PC);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "rel");

      // 6: misaligned redirect handling
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h42, "redir42");
      chk("t6.pc", o_pc, 32'h40);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "mis_load");
`ifdef IF_MISALIGN_TRAP_EN
      chk("t6.mis", {31'd0, o_if_id_misalign}, 32'd1);
      chk("t6.instr", o_if_id_instr, 32'h0000_0013);
`else
      chk("t6.mis", {31'd0, o_if_id_misalign}, 32'd0);
      chk("t6.instr", o_if_id_instr, mem[16]);
`endif
      chk("t6.valid", {31'd0, o_if_id_valid}, 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "mis_next");
      chk("t6.next_mis", {31'd0, o_if_id_misalign}, 32'd0);
      // pending flag across a stall, and cleared by a flush
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h47, "redir47");
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, "pend_stall");
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "pend_load");
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h21, "redir21");
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, "pend_flush");
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "post_flush");
      chk("t6.flush_clears", {31'd0, o_if_id_misalign}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
